// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (IF) and data (D) requesters.
// One access in flight; round-robin or data-first tie-break; one done pulse per grant.
module mem_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 64,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned PRIO_DATA = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [1:0]    d_we,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [1:0]    mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic          win_d_q, win_d_d;   // current access belongs to the D port
  logic          last_d_q, last_d_d; // most recent grant went to D
  logic          err_q, err_d;
  logic          load_q, load_d;
  logic          hi_q, hi_d;         // fetch wants the upper word
  logic          if_gnt_d, d_gnt_d, if_done_d, d_done_d, d_err_d;
  logic [31:0]   if_rdata_d;
  logic [DW-1:0] d_rdata_d, mem_wdata_d;
  logic [AW-1:0] mem_adr_d;
  logic [1:0]    mem_we_d;
  logic [1:0]    d_op;
  logic          d_mis, pick_d;
  logic          unused_if_lsbs;

  assign unused_if_lsbs = ^if_addr[1:0];

  assign d_op   = (d_we == 2'b11) ? 2'b00 : d_we;
  assign d_mis  = (d_op == 2'b01) ? (d_addr[1:0] != 2'b00) : (d_addr[2:0] != 3'b000);
  assign pick_d = d_req && (!if_req || (PRIO_DATA != 0) || !last_d_q);
  assign busy   = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    win_d_d     = win_d_q;
    last_d_d    = last_d_q;
    err_d       = err_q;
    load_d      = load_q;
    hi_d        = hi_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    mem_adr_d   = mem_adr;
    mem_we_d    = 2'b00;
    mem_wdata_d = mem_wdata;
    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d  = StAccess;
          lat_d    = LatInit;
          win_d_d  = pick_d;
          last_d_d = pick_d;
          if (pick_d) begin
            d_gnt_d = 1'b1;
            err_d   = d_mis;
            load_d  = (d_op == 2'b00);
            hi_d    = 1'b0;
            // Misaligned data accesses never reach the memory.
            if (d_mis) begin
              mem_adr_d   = '0;
              mem_wdata_d = '0;
            end else begin
              mem_adr_d   = d_addr;
              mem_we_d    = d_op;
              mem_wdata_d = d_wdata;
            end
          end else begin
            if_gnt_d    = 1'b1;
            err_d       = 1'b0;
            load_d      = 1'b0;
            hi_d        = if_addr[2];
            mem_adr_d   = {if_addr[AW-1:2], 2'b00};
            mem_wdata_d = '0;
          end
        end
      end
      StAccess: begin
        if (err_q || (lat_q == 4'd0)) begin
          state_d = StDone;
          if (win_d_q) begin
            d_done_d = 1'b1;
            d_err_d  = err_q;
            if (load_q && !err_q) d_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = hi_q ? mem_rdata[32 +: 32] : mem_rdata[31:0];
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      lat_q     <= 4'd0;
      win_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      hi_q      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_adr   <= '0;
      mem_we    <= 2'b00;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      win_d_q   <= win_d_d;
      last_d_q  <= last_d_d;
      err_q     <= err_d;
      load_q    <= load_d;
      hi_q      <= hi_d;
      if_gnt    <= if_gnt_d;
      d_gnt     <= d_gnt_d;
      if_done   <= if_done_d;
      d_done    <= d_done_d;
      d_err     <= d_err_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      mem_adr   <= mem_adr_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule
